// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   N_DEF      : default operand width
//   state_t    : controller state encoding
//   cnt_width  : width of the step counter for a given operand width
//   CNT_W_DEF  : counter width for the default operand width
package seq_multiplier_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter must be able to hold the value N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(N_DEF);

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle of the sequential multiplier.
//   go    : start/restart request
//   a, b  : unsigned operands, captured on a go edge
//   busy  : multiplication in progress
//   stp   : p holds a valid product
//   p     : 2N-bit product
// master drives requests, slave (the multiplier) drives results.
interface seq_multiplier_if #(
  parameter int N = seq_multiplier_pkg::N_DEF
);
  logic           go;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           stp;
  logic [2*N-1:0] p;

  modport master (output go, a, b, input  busy, stp, p);
  modport slave  (input  go, a, b, output busy, stp, p);
endinterface

// File: rtl/seq_multiplier_ctrl.sv
// mult_controller: FSM and step counter of the sequential multiplier.
// All state moves on the falling edge of clk.
//   clk, rst_n : clock, async active-low reset
//   go         : start/restart request (wins over everything)
//   load       : datapath captures operands this edge
//   step       : datapath performs one add-shift this edge
//   busy, stp  : registered status flags
module mult_controller
  import seq_multiplier_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  output logic load,
  output logic step,
  output logic busy,
  output logic stp
);

  localparam int CW = cnt_width(N);

  state_t        st;
  logic [CW-1:0] count;

  assign load = go;
  assign step = (st == RUN) && !go;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      stp   <= 1'b0;
    end else if (go) begin
      // restart from any state, including mid-run
      st    <= RUN;
      count <= CW'(N);
      busy  <= 1'b1;
      stp   <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          busy <= 1'b0;
          stp  <= 1'b0;
        end
        RUN: begin
          count <= count - 1'b1;
          // last step: result lands in the datapath on this same edge
          if (count == CW'(1)) begin
            st   <= DONE;
            busy <= 1'b0;
            stp  <= 1'b1;
          end
        end
        DONE: begin
          // hold result and flags until the next go
        end
        default: begin
          // 2'b11 is never entered normally; recover to IDLE
          st    <= IDLE;
          count <= '0;
          busy  <= 1'b0;
          stp   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned N x N multiplier, one add-shift per falling edge.
// Result is available exactly N falling edges after the last go edge.
//   clk, rst_n : clock (falling-edge active), async active-low reset
//   bus        : slave side of seq_multiplier_if (go, a, b -> busy, stp, p)
// Datapath: mcand holds the multiplicand, {acc, mplier} is the shifting
// partial product; consumed multiplier bits fall out the bottom while the
// product fills in from the top.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_multiplier_if.slave   bus
);

  logic         load, step;
  logic         busy, stp;
  logic [N-1:0] mcand, mplier;
  logic [N:0]   acc, sum;

  mult_controller #(.N(N)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (bus.go),
    .load  (load),
    .step  (step),
    .busy  (busy),
    .stp   (stp)
  );

  // N+1 bits so the carry of the add is kept before the shift.
  always_comb begin
    sum = acc + (mplier[0] ? {1'b0, mcand} : '0);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= bus.a;
      mplier <= bus.b;
      acc    <= '0;
    end else if (step) begin
      {acc, mplier} <= {1'b0, sum, mplier[N-1:1]};
    end
  end

  assign bus.p    = {acc[N-1:0], mplier};
  assign bus.busy = busy;
  assign bus.stp  = stp;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus random jobs.
// Driver pushes the expected product and the falling-edge index at which
// stp must rise; a monitor pops on every rising stp and compares.
module tb_seq_multiplier;
  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seq_multiplier_if #(.N(N)) bus ();

  seq_multiplier #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int prod;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   neg_cnt = 0;
  logic stp_q   = 1'b0;

  always @(negedge clk) neg_cnt++;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // monitor: samples on the rising edge, half a period after state moves
  always @(posedge clk) begin
    chk("busy_stp_exclusive", int'(bus.busy && bus.stp), 0);
    if (bus.stp && !stp_q) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_stp got stp=1 expected no pending job (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product", int'(bus.p), e.prod);
        chk("latency_edge", neg_cnt, e.due);
      end
    end
    stp_q = bus.stp;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // go is held for 'hold' edges; only the last load counts.
  task automatic issue(input int av, input int bv, input int hold);
    for (int h = 0; h < hold; h++) begin
      bus.go = 1'b1;
      bus.a  = N'(av);
      bus.b  = N'(bv);
      q.delete();
      q.push_back('{av * bv, neg_cnt + 1 + N});
      tick();
    end
    bus.go = 1'b0;
    bus.a  = N'($urandom);
    bus.b  = N'($urandom);
  endtask

  // called right after issue(): N-1 busy samples, then the result
  task automatic expect_done(input string nm, input int pexp);
    chk({nm, "_busy0"}, int'(bus.busy), 1);
    for (int i = 0; i < N - 1; i++) begin
      tick();
      chk({nm, "_busy"}, int'(bus.busy), 1);
      chk({nm, "_nostp"}, int'(bus.stp), 0);
    end
    tick();
    chk({nm, "_stp"}, int'(bus.stp), 1);
    chk({nm, "_idle"}, int'(bus.busy), 0);
    chk({nm, "_p"}, int'(bus.p), pexp);
  endtask

  initial begin
    bus.go = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_stp", int'(bus.stp), 0);
    chk("rst_p", int'(bus.p), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_stp", int'(bus.stp), 0);

    // basic job, then result holds
    issue(13, 11, 1);
    expect_done("j13x11", 143);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_p", int'(bus.p), 143);
      chk("hold_stp", int'(bus.stp), 1);
    end

    // extremes, latency independent of data
    issue(255, 255, 1);
    expect_done("j255x255", 65025);
    issue(0, 200, 1);
    expect_done("j0x200", 0);

    // back-to-back: go on the edge right after stp
    issue(12, 12, 1);
    chk("b2b_stp_drop", int'(bus.stp), 0);
    expect_done("j12x12", 144);

    // restart mid-run
    issue(7, 9, 1);
    repeat (3) tick();
    issue(6, 5, 1);
    expect_done("restart", 30);

    // go held for several edges
    issue(3, 4, 1);
    issue(17, 19, 3);
    expect_done("hold_go", 323);

    // reset mid-operation
    issue(100, 3, 1);
    repeat (4) tick();
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_stp", int'(bus.stp), 0);
    chk("midrst_p", int'(bus.p), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("postrst_stp", int'(bus.stp), 0);
    end
    issue(9, 9, 1);
    expect_done("first_after_rst", 81);

    // random jobs with random gaps (short gaps restart the job)
    for (int n = 0; n < 1000; n++) begin
      int av, bv, hold, gap;
      av   = int'($urandom_range(0, 255));
      bv   = int'($urandom_range(0, 255));
      hold = ($urandom_range(0, 9) == 0) ? 2 : 1;
      gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1))
                                         : int'($urandom_range(N, N + 4));
      issue(av, bv, hold);
      for (int g = 0; g < gap; g++) begin
        tick();
        bus.a = N'($urandom);
        bus.b = N'($urandom);
      end
    end
    repeat (N + 2) tick();
    chk("drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 4..16.
REQ-002 clk  input  1  clock; all state updates on the falling edge of clk.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 go  input  1  start/restart request, sampled on each falling edge.
REQ-005 a  input  N  multiplicand, unsigned.
REQ-006 b  input  N  multiplier, unsigned.
REQ-007 busy  output  1  high while a multiplication is in progress.
REQ-008 stp  output  1  done flag; high when p holds a valid result.
REQ-009 p  output  2N  product, unsigned.

Function
REQ-010 Datapath registers SHALL be: mcand (N bits), acc (N+1 bits, including carry), mplier (N bits) and count (ceil(log2(N+1)) bits).
REQ-011 FSM states SHALL be IDLE, RUN and DONE, with encoding from the shared package.
REQ-012 go=1 at any falling edge, in any state, SHALL load mcand<=a, mplier<=b, acc<=0 and count<=N, clear stp, and enter RUN.
REQ-013 That load SHALL take priority over all other activity, including a multiplication already in progress (restart).
REQ-014 In RUN with go=0, each falling edge SHALL perform one combined add-shift step.
REQ-015 Add-shift step: sum = acc + (mplier[0] ? mcand : 0), formed N+1 bits wide; then {acc, mplier} <= {sum, mplier} >> 1, with a 0 shifted in at the top.
REQ-016 Each add-shift step SHALL also decrement count.
REQ-017 The step that takes count from 1 to 0 SHALL move the FSM to DONE and set stp=1 on the same edge.
REQ-018 Latency: stp SHALL rise exactly N falling edges after the last edge at which go=1 was sampled.
REQ-019 Latency SHALL be independent of the operand values, including zero operands.
REQ-020 p SHALL equal {acc[N-1:0], mplier} at all times; in DONE, p = a*b exactly, with no overflow possible.
REQ-021 In DONE with go=0, all registers SHALL hold, and stp and p SHALL stay stable indefinitely.
REQ-022 In IDLE with go=0, the block SHALL hold: stp=0, busy=0.
REQ-023 busy SHALL be 1 only in RUN.
REQ-024 busy and stp SHALL never both be 1.
REQ-025 Changes on a and b outside a go=1 edge SHALL have no effect on the result.
REQ-026 go held high for several edges SHALL reload the operands on each edge; counting starts at the first edge with go=0.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, mcand=0, acc=0, mplier=0, count=0, stp=0, busy=0 and p=0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL abort that operation; no stp pulse SHALL follow the release of reset.
REQ-029 The first go=1 edge after reset release SHALL behave as in REQ-012.

Structure
REQ-030 Shared package SHALL hold the default N, the state typedef/encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the count-width constant.
REQ-031 One sub-module SHALL be used: mult_controller, holding the FSM and count and producing load, step, busy and stp.
REQ-032 The registers and the adder SHALL remain in seq_multiplier.
REQ-033 The state encoding 2'b11 SHALL be unreachable; if it is entered, the next edge SHALL go to IDLE.

Verification (N=8)
REQ-034 a=13, b=11, go high for 1 edge -> busy for 8 edges, then stp=1 and p=143; p holds for 20 further edges.
REQ-035 a=255, b=255 -> p=65025 after exactly 8 edges; also a=0, b=200 -> p=0 after exactly 8 edges, with stp timing unchanged.
REQ-036 Start a=7, b=9; at step 4 assert go with a=6, b=5 -> no stp from the first job; stp 8 edges later with p=30.
REQ-037 Start a=100, b=3; pull rst_n low at step 5 -> outputs 0 immediately; after release with no go, stp stays 0 for 20 edges.
REQ-038 Back-to-back: go on the edge right after stp=1 (a=12, b=12) -> stp drops on that edge; p=144 after 8 more edges.
REQ-039 Random: 1000 random a,b pairs and random go gaps -> p == a*b at every rising stp, and busy and stp are never both 1.
